hazard_ctrl_mc: RTL and testbench
=================================

// Module: hazard_ctrl_mc
// PURPOSE
// Second-generation hazard/forwarding controller for the 5-stage in-order core (F/D/E/M/W).
// Adds two hold mechanisms on top of forwarding, load-use stall and branch flush:
// - a multi-cycle execute unit (mul/div) that occupies E for MUL_LAT cycles;
// - a variable-latency data memory that holds M until it signals ready, with a timeout watchdog.
// Sits beside the datapath. Drives the stage-register enables/clears and the E-stage operand muxes.
// PARAMETERS
// REG_W    5     register index width (NREG = 2**REG_W); x0 is hard-wired zero
// MUL_LAT  3     total cycles a multi-cycle op occupies E; legal range >= 2
// TIMEOUT  64    consecutive memory-wait cycles before memErr is set; legal range >= 2
// PORTS
// clk       in   1      core clock, rising edge
// rst_n     in   1      asynchronous active-low reset
// rs1d,rs2d in   REG_W  source registers of the instruction in D
// rs1e,rs2e in   REG_W  source registers of the instruction in E
// rde,rdm,rdw in REG_W  destination registers in E / M / W
// rsltSrce  in   2      result select of E; 2'b01 = load
// regWrte,regWrtm,regWrtw in 1  register-write enable in E / M / W
// pcSrce    in   1      taken branch/jump resolved in E
// mulE      in   1      instruction in E is a multi-cycle op
// memReqm   in   1      instruction in M accesses data memory
// memRdym   in   1      data memory completes the access this cycle
// stallf,stalld,stalle,stallm out 1  hold the F/D/E/M pipeline register
// flushd,flushe,flushm,flushw out 1  clear the D/E/M/W register (insert bubble)
// fwdAe,fwdBe out  2    operand select: 00 = regfile, 01 = W result, 10 = M result
// mulBusy   out  1      multi-cycle FSM not IDLE
// memErr    out  1      sticky watchdog error
// BEHAVIOUR
// - Reset: async on rst_n low. mulFsm = IDLE, mulCnt = 0, wdCnt = 0, memErr = 0.
//   All other outputs are combinational and reflect the cleared state immediately,
//   including when reset hits mid-op or mid-wait.
// - Forwarding (combinational):
//   fwdAe = 10 if regWrtm & rdm==rs1e & rs1e!=0; else 01 if regWrtw & rdw==rs1e & rs1e!=0; else 00.
//   M has priority over W. fwdBe is identical, using rs2e.
// - memWait = memReqm & ~memRdym. When set: stallf/d/e/m=1, flushw=1.
//   memWait overrides every other stall source. All flushd/e/m are 0 while memWait is set.
// - mul FSM (IDLE/BUSY/DONE) advances only when memWait=0; otherwise it holds state and mulCnt.
//   IDLE & mulE: mulStall=1; go to DONE if MUL_LAT==2, else to BUSY with mulCnt=MUL_LAT-3.
//   BUSY: mulStall=1; if mulCnt==0 go to DONE, else mulCnt-=1.
//   DONE: mulStall=0; go to IDLE. DONE blocks a restart on the same instruction.
//   Result: E is held MUL_LAT-1 cycles; the op leaves E on its MUL_LAT-th cycle.
//   mulStall (with memWait=0): stallf/d/e=1, flushm=1. pcSrce is ignored while mulStall is set.
//   mulCnt width is $clog2(MUL_LAT).
// - Load-use: lwstall = (rsltSrce==01) & regWrte & rde!=0 & (rde==rs1d | rde==rs2d).
//   Evaluated only when memWait=0 and mulStall=0. lwstall gives stallf=stalld=1 and flushe=1.
// - Branch (no memWait, no mulStall): flushd = pcSrce; flushe = pcSrce | lwstall.
//   pcSrce and lwstall together: flush both, no stall (the branch wins).
// - Watchdog wdCnt:
//   memWait: wdCnt increments, saturating at TIMEOUT; memErr<=1 when wdCnt==TIMEOUT-1.
//   ~memWait: wdCnt clears. memErr is cleared only by reset.
// - mulBusy = (mulFsm != IDLE).
// TESTING
// - Forwarding: rdm=rdw=rs1e=5, regWrtm=regWrtw=1 -> fwdAe=10; rs2e=0 with rdm=0 -> fwdBe=00.
// - Load-use: rsltSrce=01, regWrte=1, rde=rs2d=7 -> stallf=stalld=flushe=1 for 1 cycle;
//   rde=0 -> no stall.
// - MUL_LAT=4, mulE held 1: stalle=1 for exactly 3 cycles with flushm=1 each;
//   4th cycle stalle=0, FSM DONE then IDLE.
// - memReqm=1, memRdym=0 for 3 cycles during mul BUSY: all stalls=1, flushw=1, mulCnt frozen;
//   mul finishes 3 cycles late.
// - TIMEOUT=4, memWait held 6 cycles -> memErr rises after the 4th wait cycle and stays 1
//   after memRdym; rst_n low mid-wait -> memErr=0 and mulBusy=0 immediately.
// - pcSrce=1 with lwstall=1 -> flushd=flushe=1, stallf=0;
//   pcSrce=1 during mulStall -> flushd=0.

Source files
------------

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for the 5-stage core: forwarding, load-use stall, branch flush,
// multi-cycle execute hold and variable-latency memory hold with a timeout watchdog.
module hazard_ctrl_mc #(
    parameter int unsigned REG_W   = 5,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs1d_i,
    input  logic [REG_W-1:0] rs2d_i,
    input  logic [REG_W-1:0] rs1e_i,
    input  logic [REG_W-1:0] rs2e_i,
    input  logic [REG_W-1:0] rde_i,
    input  logic [REG_W-1:0] rdm_i,
    input  logic [REG_W-1:0] rdw_i,
    input  logic [1:0]       rsltSrce_i,
    input  logic             regWrte_i,
    input  logic             regWrtm_i,
    input  logic             regWrtw_i,
    input  logic             pcSrce_i,
    input  logic             mulE_i,
    input  logic             memReqm_i,
    input  logic             memRdym_i,
    output logic             stallf_o,
    output logic             stalld_o,
    output logic             stalle_o,
    output logic             stallm_o,
    output logic             flushd_o,
    output logic             flushe_o,
    output logic             flushm_o,
    output logic             flushw_o,
    output logic [1:0]       fwdAe_o,
    output logic [1:0]       fwdBe_o,
    output logic             mulBusy_o,
    output logic             memErr_o
);

    localparam int unsigned CntW = $clog2(MUL_LAT);
    localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntInit = CntW'((MUL_LAT > 2) ? (MUL_LAT - 3) : 0);
    localparam logic [WdW-1:0]  WdMax   = WdW'(TIMEOUT);
    localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

    mul_state_e      mul_state_q, mul_state_d;
    logic [CntW-1:0] mul_cnt_q, mul_cnt_d;
    logic [WdW-1:0]  wd_cnt_q, wd_cnt_d;
    logic            mem_err_q, mem_err_d;
    logic            mem_wait, mul_stall, lwstall;

    assign mem_wait = memReqm_i & ~memRdym_i;
    assign lwstall  = (rsltSrce_i == 2'b01) & regWrte_i & (rde_i != '0) &
                      ((rde_i == rs1d_i) | (rde_i == rs2d_i));

    always_comb begin
        fwdAe_o = 2'b00;
        if (regWrtm_i && (rdm_i == rs1e_i) && (rs1e_i != '0)) begin
            fwdAe_o = 2'b10;
        end else if (regWrtw_i && (rdw_i == rs1e_i) && (rs1e_i != '0)) begin
            fwdAe_o = 2'b01;
        end
        fwdBe_o = 2'b00;
        if (regWrtm_i && (rdm_i == rs2e_i) && (rs2e_i != '0)) begin
            fwdBe_o = 2'b10;
        end else if (regWrtw_i && (rdw_i == rs2e_i) && (rs2e_i != '0)) begin
            fwdBe_o = 2'b01;
        end
    end

    // The FSM freezes completely while memory holds the pipe, so the op finishes late.
    always_comb begin
        mul_state_d = mul_state_q;
        mul_cnt_d   = mul_cnt_q;
        mul_stall   = 1'b0;
        unique case (mul_state_q)
            StIdle: begin
                if (mulE_i) begin
                    mul_stall = 1'b1;
                    if (!mem_wait) begin
                        if (MUL_LAT == 2) begin
                            mul_state_d = StDone;
                        end else begin
                            mul_state_d = StBusy;
                            mul_cnt_d   = CntInit;
                        end
                    end
                end
            end
            StBusy: begin
                mul_stall = 1'b1;
                if (!mem_wait) begin
                    if (mul_cnt_q == '0) begin
                        mul_state_d = StDone;
                    end else begin
                        mul_cnt_d = mul_cnt_q - CntW'(1);
                    end
                end
            end
            StDone: begin
                if (!mem_wait) begin
                    mul_state_d = StIdle;
                end
            end
            default: mul_state_d = StIdle;
        endcase
    end

    always_comb begin
        stallf_o = 1'b0;
        stalld_o = 1'b0;
        stalle_o = 1'b0;
        stallm_o = 1'b0;
        flushd_o = 1'b0;
        flushe_o = 1'b0;
        flushm_o = 1'b0;
        flushw_o = 1'b0;
        if (mem_wait) begin
            stallf_o = 1'b1;
            stalld_o = 1'b1;
            stalle_o = 1'b1;
            stallm_o = 1'b1;
            flushw_o = 1'b1;
        end else if (mul_stall) begin
            stallf_o = 1'b1;
            stalld_o = 1'b1;
            stalle_o = 1'b1;
            flushm_o = 1'b1;
        end else begin
            // A taken branch squashes the load-use victim, so no stall is needed.
            stallf_o = lwstall & ~pcSrce_i;
            stalld_o = lwstall & ~pcSrce_i;
            flushd_o = pcSrce_i;
            flushe_o = pcSrce_i | lwstall;
        end
    end

    always_comb begin
        wd_cnt_d  = '0;
        mem_err_d = mem_err_q;
        if (mem_wait) begin
            wd_cnt_d  = (wd_cnt_q == WdMax) ? wd_cnt_q : wd_cnt_q + WdW'(1);
            mem_err_d = mem_err_q | (wd_cnt_q == WdLast);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_state_q <= StIdle;
            mul_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            mul_state_q <= mul_state_d;
            mul_cnt_q   <= mul_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign mulBusy_o = (mul_state_q != StIdle);
    assign memErr_o  = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: combinational vector table plus multi-cycle sequences
// for the mul hold, memory hold, watchdog and mid-operation reset.
module tb_hazard_ctrl_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rsltSrce;
    logic       regWrte, regWrtm, regWrtw, pcSrce, mulE, memReqm, memRdym;
    logic       stallf, stalld, stalle, stallm, flushd, flushe, flushm, flushw;
    logic [1:0] fwdAe, fwdBe;
    logic       mulBusy, memErr;
    logic [3:0] stall_v, flush_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign stall_v = {stallf, stalld, stalle, stallm};
    assign flush_v = {flushd, flushe, flushm, flushw};

    hazard_ctrl_mc #(
        .REG_W   (5),
        .MUL_LAT (4),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1d_i     (rs1d),
        .rs2d_i     (rs2d),
        .rs1e_i     (rs1e),
        .rs2e_i     (rs2e),
        .rde_i      (rde),
        .rdm_i      (rdm),
        .rdw_i      (rdw),
        .rsltSrce_i (rsltSrce),
        .regWrte_i  (regWrte),
        .regWrtm_i  (regWrtm),
        .regWrtw_i  (regWrtw),
        .pcSrce_i   (pcSrce),
        .mulE_i     (mulE),
        .memReqm_i  (memReqm),
        .memRdym_i  (memRdym),
        .stallf_o   (stallf),
        .stalld_o   (stalld),
        .stalle_o   (stalle),
        .stallm_o   (stallm),
        .flushd_o   (flushd),
        .flushe_o   (flushe),
        .flushm_o   (flushm),
        .flushw_o   (flushw),
        .fwdAe_o    (fwdAe),
        .fwdBe_o    (fwdBe),
        .mulBusy_o  (mulBusy),
        .memErr_o   (memErr)
    );

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] src;
        logic [2:0] wr;     // {regWrte, regWrtm, regWrtw}
        logic       pc, req, rdy;
        logic [3:0] stall;  // {f, d, e, m}
        logic [3:0] flush;  // {d, e, m, w}
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic [4:0] a1d, a2d, a1e, a2e, ade, adm, adw,
                                input logic [1:0] src, input logic [2:0] wr,
                                input logic pc, req, rdy,
                                input logic [3:0] st, fl, input logic [1:0] fa, fb);
        vec_t v;
        v.rs1d = a1d; v.rs2d = a2d; v.rs1e = a1e; v.rs2e = a2e;
        v.rde = ade; v.rdm = adm; v.rdw = adw;
        v.src = src; v.wr = wr; v.pc = pc; v.req = req; v.rdy = rdy;
        v.stall = st; v.flush = fl; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1d = '0; rs2d = '0; rs1e = '0; rs2e = '0; rde = '0; rdm = '0; rdw = '0;
        rsltSrce = 2'b00; regWrte = 1'b0; regWrtm = 1'b0; regWrtw = 1'b0;
        pcSrce = 1'b0; mulE = 1'b0; memReqm = 1'b0; memRdym = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 3'b000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 2'd0);
        vecs[1]  = mk(0, 0, 5, 0, 0, 5, 5, 2'd0, 3'b011, 0, 0, 0, 4'b0000, 4'b0000, 2'd2, 2'd0);
        vecs[2]  = mk(0, 0, 5, 0, 0, 5, 5, 2'd0, 3'b001, 0, 0, 0, 4'b0000, 4'b0000, 2'd1, 2'd0);
        vecs[3]  = mk(0, 0, 3, 6, 0, 6, 6, 2'd0, 3'b011, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 2'd2);
        vecs[4]  = mk(0, 0, 0, 9, 0, 4, 9, 2'd0, 3'b011, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 2'd1);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 3'b011, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 2'd0);
        vecs[6]  = mk(0, 7, 0, 0, 7, 0, 0, 2'd1, 3'b100, 0, 0, 0, 4'b1100, 4'b0100, 2'd0, 2'd0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 2'd1, 3'b100, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 2'd0);
        vecs[8]  = mk(7, 3, 0, 0, 7, 0, 0, 2'd1, 3'b100, 0, 0, 0, 4'b1100, 4'b0100, 2'd0, 2'd0);
        vecs[9]  = mk(7, 0, 0, 0, 7, 0, 0, 2'd2, 3'b100, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 2'd0);
        vecs[10] = mk(7, 0, 0, 0, 7, 0, 0, 2'd1, 3'b000, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 2'd0);
        vecs[11] = mk(0, 7, 0, 0, 7, 0, 0, 2'd1, 3'b100, 1, 0, 0, 4'b0000, 4'b1100, 2'd0, 2'd0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 3'b000, 1, 0, 0, 4'b0000, 4'b1100, 2'd0, 2'd0);
        vecs[13] = mk(0, 7, 5, 0, 7, 5, 0, 2'd1, 3'b110, 1, 1, 0, 4'b1111, 4'b0001, 2'd2, 2'd0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 2'd0, 3'b000, 0, 1, 1, 4'b0000, 4'b0000, 2'd0, 2'd0);

        clear_inputs();
        rst_n = 1'b0;
        #2;
        chk("reset_mulBusy", 32'(mulBusy), 32'd0);
        chk("reset_memErr", 32'(memErr), 32'd0);
        chk("reset_stall", 32'(stall_v), 32'd0);
        chk("reset_flush", 32'(flush_v), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational table: FSM stays idle because mulE is never raised here.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rs1d = vecs[i].rs1d; rs2d = vecs[i].rs2d; rs1e = vecs[i].rs1e;
            rs2e = vecs[i].rs2e; rde = vecs[i].rde; rdm = vecs[i].rdm; rdw = vecs[i].rdw;
            rsltSrce = vecs[i].src;
            {regWrte, regWrtm, regWrtw} = vecs[i].wr;
            pcSrce = vecs[i].pc; memReqm = vecs[i].req; memRdym = vecs[i].rdy;
            #2;
            chk($sformatf("vec%0d_stall", i), 32'(stall_v), 32'(vecs[i].stall));
            chk($sformatf("vec%0d_flush", i), 32'(flush_v), 32'(vecs[i].flush));
            chk($sformatf("vec%0d_fwdA", i), 32'(fwdAe), 32'(vecs[i].fa));
            chk($sformatf("vec%0d_fwdB", i), 32'(fwdBe), 32'(vecs[i].fb));
        end

        // Mul op, MUL_LAT=4, with a taken branch held: branch must be ignored while stalled.
        @(negedge clk);
        clear_inputs();
        mulE = 1'b1;
        pcSrce = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #2;
            chk($sformatf("mul_c%0d_stall", c), 32'(stall_v), (c <= 3) ? 32'hE : 32'h0);
            chk($sformatf("mul_c%0d_flush", c), 32'(flush_v), (c <= 3) ? 32'h2 : 32'hC);
            chk($sformatf("mul_c%0d_busy", c), 32'(mulBusy), (c >= 2) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        clear_inputs();
        #2;
        chk("mul_idle_busy", 32'(mulBusy), 32'd0);
        chk("mul_idle_stall", 32'(stall_v), 32'd0);

        // Mul op with a 3-cycle memory wait in BUSY: done arrives 3 cycles late.
        @(negedge clk);
        mulE = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            memReqm = (c >= 2 && c <= 4);
            memRdym = 1'b0;
            if (c == 8) mulE = 1'b0;
            #2;
            if (c >= 2 && c <= 4) begin
                chk($sformatf("mw_c%0d_stall", c), 32'(stall_v), 32'hF);
                chk($sformatf("mw_c%0d_flush", c), 32'(flush_v), 32'h1);
            end else begin
                chk($sformatf("mw_c%0d_stall", c), 32'(stall_v), (c <= 6) ? 32'hE : 32'h0);
                chk($sformatf("mw_c%0d_flush", c), 32'(flush_v), (c <= 6) ? 32'h2 : 32'h0);
            end
            chk($sformatf("mw_c%0d_busy", c), 32'(mulBusy), (c >= 2 && c <= 7) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk("mw_memErr", 32'(memErr), 32'd0);

        // Watchdog: six wait cycles, error visible from the fifth, sticky after ready.
        clear_inputs();
        memReqm = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            #2;
            chk($sformatf("wd_c%0d_memErr", c), 32'(memErr), (c >= 5) ? 32'd1 : 32'd0);
            chk($sformatf("wd_c%0d_stallm", c), 32'(stallm), 32'd1);
            @(negedge clk);
        end
        memRdym = 1'b1;
        #2;
        chk("wd_rdy_memErr", 32'(memErr), 32'd1);
        chk("wd_rdy_stallm", 32'(stallm), 32'd0);
        @(negedge clk);
        clear_inputs();
        #2;
        chk("wd_sticky_memErr", 32'(memErr), 32'd1);

        // Reset mid-wait with mul busy: state clears without a clock edge.
        @(negedge clk);
        mulE = 1'b1;
        @(negedge clk);
        memReqm = 1'b1;
        #2;
        chk("rst_pre_busy", 32'(mulBusy), 32'd1);
        chk("rst_pre_memErr", 32'(memErr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(mulBusy), 32'd0);
        chk("rst_mid_memErr", 32'(memErr), 32'd0);
        chk("rst_mid_stall", 32'(stall_v), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        #2;
        chk("rst_post_stall", 32'(stall_v), 32'h0);
        chk("rst_post_busy", 32'(mulBusy), 32'd0);
        @(negedge clk);
        #2;
        chk("rst_post_memErr", 32'(memErr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
